// File: rtl/bitop_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bitop_pkg
// Purpose  : Shared types and helpers for the sequential bit changer.
//            - op_e    : 3-bit command opcode
//            - state_e : FSM state encoding (IDLE / SWEEP)
//            - is_range, to_single : opcode classification helpers
// Revision : 1.0 - initial release
// ============================================================================
package bitop_pkg;

  // Width used when zero-extending index magnitudes for compares against N.
  localparam int IDX_EXT_W = 32;

  typedef enum logic [2:0] {
    OP_NOP          = 3'd0,
    OP_LOAD         = 3'd1,
    OP_TOGGLE       = 3'd2,
    OP_SET          = 3'd3,
    OP_CLEAR        = 3'd4,
    OP_RANGE_TOGGLE = 3'd5,
    OP_RANGE_SET    = 3'd6,
    OP_RANGE_CLEAR  = 3'd7
  } op_e;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

  // True for the multi-cycle range opcodes.
  function automatic logic is_range(op_e op);
    return (op == OP_RANGE_TOGGLE) || (op == OP_RANGE_SET) || (op == OP_RANGE_CLEAR);
  endfunction

  // Map a range opcode onto the single-bit opcode applied at each sweep step.
  function automatic op_e to_single(op_e op);
    op_e r;
    case (op)
      OP_RANGE_TOGGLE: r = OP_TOGGLE;
      OP_RANGE_SET:    r = OP_SET;
      OP_RANGE_CLEAR:  r = OP_CLEAR;
      default:         r = op;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bit_idx_check.sv
`default_nettype none
// ============================================================================
// Module   : bit_idx_check
// Purpose  : Combinational sign-magnitude index checker.
//            An index is valid when its sign bit is 0 and its magnitude is
//            below N.
// Ports    : i_idx   [IW-1:0]  index, MSB = sign, remaining bits = magnitude
//            o_valid           index addresses an existing bit
//            o_mag   [IW-2:0]  magnitude field of the index
// Revision : 1.0 - initial release
// ============================================================================
module bit_idx_check
  import bitop_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = 8
) (
  input  logic [IW-1:0] i_idx,
  output logic          o_valid,
  output logic [IW-2:0] o_mag
);

  logic [IDX_EXT_W-1:0] w_mag_ext;

  assign o_mag     = i_idx[IW-2:0];
  assign w_mag_ext = IDX_EXT_W'(i_idx[IW-2:0]);
  assign o_valid   = !i_idx[IW-1] && (w_mag_ext < IDX_EXT_W'(N));

endmodule
`default_nettype wire

// File: rtl/bit_changer_seq.sv
`default_nettype none
// ============================================================================
// Module   : bit_changer_seq
// Purpose  : N-bit working register driven by bit-manipulation commands over
//            a valid/ready handshake. Single-bit ops and LOAD complete in one
//            cycle; range ops sweep one bit per clock from low to high bound.
// Ports    : i_clk, i_rst        clock, asynchronous active-high reset
//            i_valid / o_ready   command handshake (o_ready == FSM in IDLE)
//            i_op   [2:0]        opcode (op_e)
//            i_a    [N-1:0]      load data
//            i_b    [IW-1:0]     bit index / range low bound
//            i_c    [IW-1:0]     range high bound
//            o_out  [N-1:0]      working register
//            o_valid             one-cycle completion pulse
//            o_ERR               error status of last completed command
// Revision : 1.0 - initial release
// ============================================================================
module bit_changer_seq
  import bitop_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [2:0]    i_op,
  input  logic [N-1:0]  i_a,
  input  logic [IW-1:0] i_b,
  input  logic [IW-1:0] i_c,
  output logic [N-1:0]  o_out,
  output logic          o_valid,
  output logic          o_ERR
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int MW = IW - 1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e        r_state;
  op_e           r_op;
  logic [CW-1:0] r_cursor;
  logic [CW-1:0] r_hi;
  logic [N-1:0]  r_out;
  logic          r_valid;
  logic          r_err;

  // --------------------------------------------------------------------------
  // Index decode
  // --------------------------------------------------------------------------
  logic          w_b_ok;
  logic          w_c_ok;
  logic [MW-1:0] w_b_mag;
  logic [MW-1:0] w_c_mag;

  bit_idx_check #(.N(N), .IW(IW)) u_idx_b (
    .i_idx   (i_b),
    .o_valid (w_b_ok),
    .o_mag   (w_b_mag)
  );

  bit_idx_check #(.N(N), .IW(IW)) u_idx_c (
    .i_idx   (i_c),
    .o_valid (w_c_ok),
    .o_mag   (w_c_mag)
  );

  op_e  w_op;
  logic w_accept;
  logic w_err;

  assign w_op     = op_e'(i_op);
  assign w_accept = i_valid && (r_state == ST_IDLE);

  always_comb begin
    w_err = 1'b0;
    case (w_op)
      OP_TOGGLE, OP_SET, OP_CLEAR:
        w_err = !w_b_ok;
      OP_RANGE_TOGGLE, OP_RANGE_SET, OP_RANGE_CLEAR:
        w_err = !w_b_ok || !w_c_ok || (w_b_mag > w_c_mag);
      default:
        w_err = 1'b0;
    endcase
  end

  // Once validated the magnitude is < N, so truncating to the cursor width
  // loses nothing; invalid indices never reach the mask because the error
  // path leaves the register untouched.
  logic [CW-1:0] w_b_sel;
  logic [CW-1:0] w_c_sel;
  logic [N-1:0]  w_b_mask;
  logic [N-1:0]  w_cur_mask;

  assign w_b_sel = CW'(w_b_mag);
  assign w_c_sel = CW'(w_c_mag);

  for (genvar g = 0; g < N; g++) begin : g_mask
    assign w_b_mask[g]   = (w_b_sel  == CW'(g));
    assign w_cur_mask[g] = (r_cursor == CW'(g));
  end

  // Apply a single-bit operation selected by a one-hot mask.
  function automatic logic [N-1:0] apply_bit(op_e op, logic [N-1:0] cur, logic [N-1:0] mask);
    logic [N-1:0] r;
    case (op)
      OP_TOGGLE: r = cur ^ mask;
      OP_SET:    r = cur | mask;
      OP_CLEAR:  r = cur & ~mask;
      default:   r = cur;
    endcase
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // FSM, register and output flops
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_NOP;
      r_cursor <= '0;
      r_hi     <= '0;
      r_out    <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_err) begin
              r_valid <= 1'b1;
              r_err   <= 1'b1;
            end else if (is_range(w_op)) begin
              // Latch everything the sweep needs so input changes are ignored.
              r_state  <= ST_SWEEP;
              r_op     <= to_single(w_op);
              r_cursor <= w_b_sel;
              r_hi     <= w_c_sel;
            end else begin
              if (w_op == OP_LOAD) begin
                r_out <= i_a;
              end else begin
                r_out <= apply_bit(w_op, r_out, w_b_mask);
              end
              r_valid <= 1'b1;
              r_err   <= 1'b0;
            end
          end
        end
        ST_SWEEP: begin
          r_out <= apply_bit(r_op, r_out, w_cur_mask);
          if (r_cursor == r_hi) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b1;
            r_err   <= 1'b0;
          end else begin
            r_cursor <= r_cursor + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_ready = (r_state == ST_IDLE);
  assign o_out   = r_out;
  assign o_valid = r_valid;
  assign o_ERR   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bit_changer_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_changer_seq
// Purpose  : Scoreboard bench for bit_changer_seq (N=8, IW=8). The driver
//            pushes the expected register/error value of each command that
//            completes; a monitor pops on every o_valid pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit_changer_seq;

  logic       clk;
  logic       rst;
  logic       i_valid;
  logic       o_ready;
  logic [2:0] i_op;
  logic [7:0] i_a;
  logic [7:0] i_b;
  logic [7:0] i_c;
  logic [7:0] o_out;
  logic       o_valid;
  logic       o_ERR;

  typedef struct {
    logic [7:0] out;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  bit_changer_seq #(.N(8), .IW(8)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_op    (i_op),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_c     (i_c),
    .o_out   (o_out),
    .o_valid (o_valid),
    .o_ERR   (o_ERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present a command (i_valid left high) and step to just after the edge.
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input bit push, input logic [7:0] eo, input logic ee);
    exp_t e;
    i_valid = 1'b1;
    i_op    = op;
    i_a     = a;
    i_b     = b;
    i_c     = c;
    if (push) begin
      e.out = eo;
      e.err = ee;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_valid = 1'b0;
    i_op    = 3'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every completion pulse must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && o_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'(o_valid), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_out", 32'(o_out), 32'(e.out));
          check("sb_err", 32'(o_ERR), 32'(e.err));
        end
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    i_valid = 1'b0;
    i_op = 3'd0;
    i_a = 8'h00;
    i_b = 8'h00;
    i_c = 8'h00;
    step();
    step();
    rst = 1'b0;
    check("rst_out",   32'(o_out),   32'h00);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_err",   32'(o_ERR),   32'd0);

    // Async reset between edges clears a non-zero register and a set error.
    send(3'd1, 8'h5A, 8'h00, 8'h00, 1, 8'h5A, 1'b0);
    send(3'd2, 8'h00, 8'h83, 8'h00, 1, 8'h5A, 1'b1);
    idle();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("arst_out",   32'(o_out),   32'h00);
    check("arst_ready", 32'(o_ready), 32'd1);
    check("arst_valid", 32'(o_valid), 32'd0);
    check("arst_err",   32'(o_ERR),   32'd0);
    step();
    rst = 1'b0;
    step();

    // LOAD then single-bit toggle.
    send(3'd1, 8'hA5, 8'h00, 8'h00, 1, 8'hA5, 1'b0);
    send(3'd2, 8'h00, 8'h03, 8'h00, 1, 8'hAD, 1'b0);
    idle();
    step();

    // Index errors: sign set, magnitude == N, reversed range.
    send(3'd2, 8'h00, 8'h83, 8'h00, 1, 8'hAD, 1'b1);
    send(3'd2, 8'h00, 8'h08, 8'h00, 1, 8'hAD, 1'b1);
    send(3'd6, 8'h00, 8'h05, 8'h02, 1, 8'hAD, 1'b1);
    check("err_range_ready", 32'(o_ready), 32'd1);
    idle();
    step();

    // Range sweep 2..5 from 0x00; a competing command is offered mid-sweep.
    send(3'd1, 8'h00, 8'h00, 8'h00, 1, 8'h00, 1'b0);
    send(3'd6, 8'h00, 8'h02, 8'h05, 1, 8'h3C, 1'b0);
    check("sweep_ready0", 32'(o_ready), 32'd0);
    check("sweep_out0",   32'(o_out),   32'h00);
    i_op = 3'd1;
    i_a  = 8'hFF;
    i_b  = 8'h00;
    i_c  = 8'h07;
    step();
    check("sweep_out1", 32'(o_out),   32'h04);
    check("sweep_rdy1", 32'(o_ready), 32'd0);
    step();
    check("sweep_out2", 32'(o_out),   32'h0C);
    step();
    check("sweep_out3", 32'(o_out),   32'h1C);
    check("sweep_rdy3", 32'(o_ready), 32'd0);
    step();
    idle();
    check("sweep_out4", 32'(o_out),   32'h3C);
    check("sweep_rdy4", 32'(o_ready), 32'd1);
    step();
    check("sweep_hold", 32'(o_out),   32'h3C);

    // Reset in the middle of a full-width range toggle: no completion pulse.
    send(3'd1, 8'h00, 8'h00, 8'h00, 1, 8'h00, 1'b0);
    send(3'd5, 8'h00, 8'h00, 8'h07, 0, 8'h00, 1'b0);
    idle();
    step();
    check("mid_out1", 32'(o_out), 32'h01);
    step();
    check("mid_out2", 32'(o_out), 32'h03);
    step();
    check("mid_out3", 32'(o_out), 32'h07);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out",   32'(o_out),   32'h00);
    check("mid_rst_ready", 32'(o_ready), 32'd1);
    check("mid_rst_valid", 32'(o_valid), 32'd0);
    step();
    rst = 1'b0;
    step();
    step();
    check("mid_no_pulse_q", 32'(exp_q.size()), 32'd0);

    // Back-to-back: second command accepted in the first one's o_valid cycle.
    send(3'd2, 8'h00, 8'h00, 8'h00, 1, 8'h01, 1'b0);
    check("b2b_out1",   32'(o_out),   32'h01);
    check("b2b_valid1", 32'(o_valid), 32'd1);
    send(3'd7, 8'h00, 8'h00, 8'h00, 1, 8'h00, 1'b0);
    idle();
    check("b2b_ready", 32'(o_ready), 32'd0);
    check("b2b_hold",  32'(o_out),   32'h01);
    step();
    check("b2b_out2",   32'(o_out),   32'h00);
    check("b2b_valid2", 32'(o_valid), 32'd1);
    check("b2b_ready2", 32'(o_ready), 32'd1);
    step();
    check("b2b_valid3", 32'(o_valid), 32'd0);
    step();
    step();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bit_changer_seq.md
Name: bit_changer_seq

Overview:
- Sequential, parametrised successor of the combinational single-bit toggler.
- Holds an N-bit working register and accepts bit-manipulation commands over a valid/ready handshake: load, single-bit toggle/set/clear, and multi-cycle range toggle/set/clear.
- Bit indices use the existing sign-magnitude convention: MSB is the sign, the rest is the magnitude.
- Invalid indices raise o_ERR and leave the register untouched. Sits between the control FSM and any consumer of the bit mask.

Parameters:
- N, 8, width of the working register and of i_a/o_out.
- IW, 8, width of each index input; MSB is the sign, IW-1 magnitude bits.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_valid  input  1  command present.
- o_ready  output  1  block can accept a command; high exactly when the FSM is in IDLE.
- i_op  input  3  opcode, see Behaviour.
- i_a  input  N  load data; used by LOAD only.
- i_b  input  IW  index / range low bound.
- i_c  input  IW  range high bound; used by RANGE ops only.
- o_out  output  N  working register, always visible.
- o_valid  output  1  one-cycle completion pulse, registered.
- o_ERR  output  1  error status of the last completed command, registered.

Behaviour:
- Reset:
  - o_out=0, o_valid=0, o_ERR=0, FSM=IDLE, cursor=0, so o_ready=1.
  - Reset is asynchronous: asserting i_rst mid-range aborts the sweep immediately with no completion pulse.
- Accept: a command is accepted at a rising edge where i_valid && o_ready. Commands offered while o_ready=0 are ignored, not queued.
- Opcodes:
  - 0 NOP
  - 1 LOAD (o_out=i_a)
  - 2 TOGGLE, 3 SET, 4 CLEAR: act on bit mag(i_b)
  - 5 RANGE_TOGGLE, 6 RANGE_SET, 7 RANGE_CLEAR: act on bits mag(i_b)..mag(i_c) inclusive
- Index validity:
  - An index is valid iff its sign bit is 0 and its magnitude is < N.
  - A RANGE op additionally requires mag(i_b) <= mag(i_c).
  - Ops 2-4 check i_b only. Ops 5-7 check i_b and i_c. NOP and LOAD never error.
- Single-cycle ops (NOP, LOAD, 2-4):
  - o_out is updated at the accept edge.
  - o_valid=1 and o_ERR are set for the following cycle.
  - FSM stays in IDLE.
- Erroneous command (any opcode):
  - o_out is unchanged at the accept edge.
  - o_valid=1 and o_ERR=1 for the following cycle.
  - No SWEEP state is entered.
- Valid RANGE op:
  - Accept edge: FSM goes to SWEEP, cursor=mag(i_b); the opcode and hi bound are latched.
  - Each SWEEP edge applies the operation to bit cursor.
  - If cursor==hi at that edge: FSM returns to IDLE and o_valid is set (o_ERR=0). Otherwise cursor increments.
  - A range of k bits therefore finishes k edges after accept. The intermediate o_out values are visible bit by bit.
- o_valid is high for exactly one cycle per accepted command and is 0 otherwise.
- o_ERR holds its value until the next command completes.
- In the cycle o_valid=1 the FSM is IDLE, so a new command may be accepted in that same cycle. Back-to-back throughput is 1 command per cycle for single-cycle ops.
- Width rules:
  - Index compares are done on the IW-1 magnitude bits zero-extended against N.
  - The bit mask is a one-hot of width N; magnitudes >= N never reach the mask logic.
- Latched range inputs: i_a/i_b/i_c/i_op changes during SWEEP have no effect.

Decomposition:
- Shared package bitop_pkg:
  - op_e enum (NOP, LOAD, TOGGLE, SET, CLEAR, RANGE_TOGGLE, RANGE_SET, RANGE_CLEAR; 3-bit)
  - state_e enum (IDLE, SWEEP)
  - helper function is_range(op_e)
- Sub-module bit_idx_check: combinational, parametrised by N and IW. Input is an index; outputs are valid and mag. Instantiated twice, for i_b and i_c.
- Top module holds the FSM, cursor, latched op/hi, register and output flops.

Test Plan:
- Reset (N=8, IW=8): assert i_rst asynchronously between edges -> o_out=0x00, o_ready=1, o_valid=0, o_ERR=0 immediately.
- Single-bit op: LOAD i_a=0xA5, then TOGGLE i_b=3 -> o_out=0xA5 then 0xAD; o_valid pulses once per command, o_ERR=0.
- Index errors: TOGGLE i_b=0x83 (sign set) -> o_ERR=1, o_out stays 0xAD. TOGGLE i_b=8 -> o_ERR=1. RANGE_SET i_b=5, i_c=2 -> o_ERR=1, o_ready never drops.
- Range sweep: from 0x00, RANGE_SET i_b=2, i_c=5 -> o_out steps 0x04, 0x0C, 0x1C, 0x3C on successive edges; o_ready=0 for 4 cycles; o_valid pulses after the 4th edge; i_valid with another command during the sweep is ignored.
- Reset mid-sweep: RANGE_TOGGLE 0..7 from 0x00, assert i_rst after 3 edges -> o_out=0x00 asynchronously, FSM IDLE, no o_valid pulse.
- Back-to-back: hold i_valid with TOGGLE 0 then RANGE_CLEAR i_b=i_c=0 from 0x00 -> 0x01 after the first edge; the second command is accepted in the o_valid cycle; 1-bit range finishes 1 edge after its accept; final o_out=0x00.
